// File: rtl/lsb_serial_sub_if.sv
// Purpose: operand/result bundle for the digit-serial subtractor.
// Ports: master drives start/a/b/b_in and observes busy/done/d/b_out(/ovf);
//        slave is the subtractor side. ovf exists only with LSB_SERIAL_SUB_OVF_EN.
interface lsb_serial_sub_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             b_out;
`ifdef LSB_SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (output start, a, b, b_in, input busy, done, d, b_out, ovf);
   modport slave  (input start, a, b, b_in, output busy, done, d, b_out, ovf);
`else
   modport master (output start, a, b, b_in, input busy, done, d, b_out);
   modport slave  (input start, a, b, b_in, output busy, done, d, b_out);
`endif
endinterface

// File: rtl/lsb_serial_sub.sv
// Purpose: digit-serial subtractor, D = A - B - B_in, NIB bits per clock, LSB digit first.
// Latency: start accepted at edge k -> done/d/b_out valid after edge k+WIDTH/NIB.
// Backpressure: start is only honoured in IDLE/FIN; it is ignored while busy.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport of lsb_serial_sub_if).
// Option: define LSB_SERIAL_SUB_OVF_EN to add the signed-overflow flag bus.ovf.
module lsb_serial_sub #(
   parameter int WIDTH = 16,
   parameter int NIB   = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   lsb_serial_sub_if.slave    bus
);
   localparam int NDIG = WIDTH / NIB;
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              borrow_q, borrow_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  acc_q, acc_d;    // digits assembled so far, hidden from d
   logic [WIDTH-1:0]  d_q, d_d;
   logic              b_out_q, b_out_d;
`ifdef LSB_SERIAL_SUB_OVF_EN
   logic              ovf_q, ovf_d;
`endif

   logic [NIB-1:0]    a_dig, b_dig;
   logic [NIB:0]      diff;            // top bit is the borrow out of this digit

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      d_d      = d_q;
      b_out_d  = b_out_q;
`ifdef LSB_SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif

      a_dig = a_q[int'(idx_q)*NIB +: NIB];
      b_dig = b_q[int'(idx_q)*NIB +: NIB];
      diff  = {1'b0, a_dig} - {1'b0, b_dig} - {{NIB{1'b0}}, borrow_q};

      case (state_q)
         IDLE, FIN: begin
            if (bus.start) begin
               state_d  = RUN;
               a_d      = bus.a;
               b_d      = bus.b;
               borrow_d = bus.b_in;
               idx_d    = '0;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            acc_d[int'(idx_q)*NIB +: NIB] = diff[NIB-1:0];
            borrow_d = diff[NIB];
            idx_d    = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               // Result becomes visible only once the MSB digit is done.
               state_d  = FIN;
               idx_d    = '0;
               d_d      = acc_d;
               b_out_d  = diff[NIB];
`ifdef LSB_SERIAL_SUB_OVF_EN
               ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (acc_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         d_q      <= '0;
         b_out_q  <= 1'b0;
`ifdef LSB_SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         d_q      <= d_d;
         b_out_q  <= b_out_d;
`ifdef LSB_SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.busy  = (state_q == RUN);
   assign bus.done  = (state_q == FIN);
   assign bus.d     = d_q;
   assign bus.b_out = b_out_q;
`ifdef LSB_SERIAL_SUB_OVF_EN
   assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_lsb_serial_sub.sv
// Purpose: directed self-checking bench for lsb_serial_sub (WIDTH=16, NIB=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Honours LSB_SERIAL_SUB_OVF_EN for the overflow flag.
module tb_lsb_serial_sub;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [15:0] last_d = 16'h0000;

   always #5 clk = ~clk;

   lsb_serial_sub_if #(.WIDTH(16)) sub_if ();

   lsb_serial_sub #(.WIDTH(16), .NIB(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (sub_if.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation; inputs are scrambled right after acceptance.
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic bin, input logic [15:0] ed, input logic ebo,
                         input logic eovf);
      int n;
      sub_if.a = av; sub_if.b = bv; sub_if.b_in = bin; sub_if.start = 1'b1;
      tick();
      sub_if.start = 1'b0;
      sub_if.a = ~av; sub_if.b = ~bv; sub_if.b_in = ~bin;
      n = 0;
      while (!sub_if.done && n < 20) begin
         chk({tag, "_busy"}, {31'd0, sub_if.busy}, 32'd1);
         chk({tag, "_hold"}, {16'd0, sub_if.d}, {16'd0, last_d});
         tick();
         n++;
      end
      chk({tag, "_lat"}, n, 32'd4);
      chk({tag, "_d"}, {16'd0, sub_if.d}, {16'd0, ed});
      chk({tag, "_bout"}, {31'd0, sub_if.b_out}, {31'd0, ebo});
`ifdef LSB_SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, {31'd0, sub_if.ovf}, {31'd0, eovf});
`else
      if (eovf === 1'bx) $display("unreachable");
`endif
      last_d = ed;
      tick();
      chk({tag, "_done1"}, {31'd0, sub_if.done}, 32'd0);
      chk({tag, "_dhold"}, {16'd0, sub_if.d}, {16'd0, ed});
   endtask

   initial begin
      int n;
      int dones;
      sub_if.start = 1'b0; sub_if.a = '0; sub_if.b = '0; sub_if.b_in = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", {31'd0, sub_if.busy}, 32'd0);
      chk("rst_done", {31'd0, sub_if.done}, 32'd0);
      chk("rst_d", {16'd0, sub_if.d}, 32'd0);
      chk("rst_bout", {31'd0, sub_if.b_out}, 32'd0);
`ifdef LSB_SERIAL_SUB_OVF_EN
      chk("rst_ovf", {31'd0, sub_if.ovf}, 32'd0);
`endif

      // Basic, full borrow ripple, signed overflow.
      run_op("t1", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
      run_op("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      run_op("t3", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1);

      // START during RUN is ignored.
      sub_if.a = 16'h0005; sub_if.b = 16'h0003; sub_if.b_in = 1'b0; sub_if.start = 1'b1;
      tick();
      sub_if.a = 16'hFFFF; sub_if.b = 16'h0000;
      tick(); tick();
      sub_if.start = 1'b0;
      n = 0;
      while (!sub_if.done && n < 20) begin tick(); n++; end
      chk("t4_lat", n, 32'd2);
      chk("t4_d", {16'd0, sub_if.d}, 32'h0002);
      chk("t4_bout", {31'd0, sub_if.b_out}, 32'd0);
      dones = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (sub_if.done) dones++; end
      chk("t4_single", dones, 32'd0);

      // Reset mid-operation aborts it.
      sub_if.a = 16'h1234; sub_if.b = 16'h0001; sub_if.start = 1'b1;
      tick();
      sub_if.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy", {31'd0, sub_if.busy}, 32'd0);
      chk("t5_d", {16'd0, sub_if.d}, 32'd0);
      chk("t5_done", {31'd0, sub_if.done}, 32'd0);
      dones = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (sub_if.done) dones++; end
      chk("t5_nodone", dones, 32'd0);
      last_d = 16'h0000;
      run_op("t5b", 16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, 1'b0);

      // Back-to-back: START held high, second pair accepted in FIN.
      sub_if.a = 16'h1111; sub_if.b = 16'h0001; sub_if.b_in = 1'b0; sub_if.start = 1'b1;
      tick();
      sub_if.a = 16'hAAAA; sub_if.b = 16'h5555;
      n = 0;
      while (!sub_if.done && n < 20) begin tick(); n++; end
      chk("t6_lat1", n, 32'd4);
      chk("t6_d1", {16'd0, sub_if.d}, 32'h1110);
      tick();
      sub_if.start = 1'b0;
      chk("t6_busy2", {31'd0, sub_if.busy}, 32'd1);
      n = 1;
      while (!sub_if.done && n < 20) begin tick(); n++; end
      chk("t6_gap", n, 32'd5);
      chk("t6_d2", {16'd0, sub_if.d}, 32'h5555);
      chk("t6_bout2", {31'd0, sub_if.b_out}, 32'd0);
`ifdef LSB_SERIAL_SUB_OVF_EN
      chk("t6_ovf2", {31'd0, sub_if.ovf}, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/lsb_serial_sub.md
LSB_SERIAL_SUB -- requirements
Module: lsb_serial_sub

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be a multiple of NIB.
REQ-002 Parameter NIB, default 4: digit width in bits processed per clock.
REQ-003 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 START  input  1  request pulse; SHALL be sampled only when the block is ready (REQ-013).
REQ-006 A  input  WIDTH  minuend; SHALL be captured on an accepted START.
REQ-007 B  input  WIDTH  subtrahend; SHALL be captured on an accepted START.
REQ-008 B_in  input  1  borrow-in; SHALL be captured on an accepted START.
REQ-009 BUSY  output  1  SHALL be high while digits are being processed.
REQ-010 DONE  output  1  single-cycle completion strobe.
REQ-011 D  output  WIDTH  difference, D = A - B - B_in (mod 2^WIDTH).
REQ-012 B_out  output  1  borrow-out of the MSB digit: 1 when A < B + B_in, unsigned.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIN. It is ready in IDLE and FIN.
REQ-014 IDLE -> RUN on START=1; operands, B_in and digit index = 0 are latched at that edge.
REQ-015 RUN: each cycle SHALL subtract digit i (bits i*NIB+NIB-1 : i*NIB) using the borrow from digit i-1, LSB digit first, then increment i.
REQ-016 The digit 0 borrow SHALL be the latched B_in; the borrow SHALL be registered between digits.
REQ-017 RUN -> FIN after digit WIDTH/NIB-1 is processed, so RUN lasts exactly WIDTH/NIB cycles (4 at default).
REQ-018 Latency: START accepted at edge k -> DONE=1, D and B_out valid in the cycle after edge k+WIDTH/NIB (edge k+4 at default).
REQ-019 FIN SHALL last one cycle with DONE=1, then go to IDLE; with START=1 in FIN, FIN -> RUN with new operands latched (back-to-back, no idle cycle).
REQ-020 BUSY SHALL equal (state == RUN); DONE SHALL equal (state == FIN).
REQ-021 D and B_out SHALL update only on the edge entering FIN and hold until the next completion; partial digits SHALL NOT be visible on D.
REQ-022 START in RUN SHALL be ignored, with no effect on operands, index or result.
REQ-023 Changes on A, B or B_in after acceptance SHALL NOT affect the result.
REQ-024 Arithmetic SHALL be pure two's-complement wrap; there SHALL be no saturation.

Reset
REQ-025 With RST=1 at a rising edge, the state SHALL become IDLE and the digit index and internal borrow SHALL clear to 0.
REQ-026 On reset, BUSY=0, DONE=0, D=0, B_out=0, and OVF=0 when present.
REQ-027 RST SHALL take priority over START. Reset during RUN SHALL abort the operation; no DONE SHALL be issued for the aborted operation.

Configuration
REQ-028 Macro LSB_SERIAL_SUB_OVF_EN, when defined, SHALL add output OVF (1 bit, after B_out), updated with D.
REQ-029 OVF SHALL be 1 when A[WIDTH-1] != B[WIDTH-1] and D[WIDTH-1] != A[WIDTH-1] (signed overflow).
REQ-030 Without LSB_SERIAL_SUB_OVF_EN, the OVF port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 A=0x1234, B=0x0034, B_in=0, START at edge k -> BUSY high for 4 cycles, DONE at k+4, D=0x1200, B_out=0.
REQ-032 A=0x0000, B=0x0001, B_in=0 -> D=0xFFFF, B_out=1; borrow propagates across all 4 digits.
REQ-033 A=0x8000, B=0x0000, B_in=1 -> D=0x7FFF, B_out=0, OVF=1 (macro defined); port absent (macro undefined).
REQ-034 START with A=0x0005, B=0x0003, then START with A=0xFFFF during RUN -> single DONE, D=0x0002.
REQ-035 RST=1 two cycles after START -> no DONE; D=0, BUSY=0; a following START (0x00F0 - 0x000F) -> D=0x00E1.
REQ-036 START held high through FIN with a second operand pair 0xAAAA - 0x5555 -> DONE pulses 5 cycles apart; second D=0x5555, B_out=0.
